uart_tx_arbiter: RTL

Shares one serial UART transmit line between N_REQ byte requesters using round-robin arbitration. The block also sequences the 8N1 frame itself: start bit, 8 data bits LSB first, stop bit, each exactly BAUD_DIV clocks long. It sits between on-chip byte sources (switch sender, monitor, debug echo) and the board tx pin, replacing per-source transmitters.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmit line
// between N_REQ byte sources. The frame sequencer is built in: start bit,
// 8 data bits LSB first, optional even-parity bit, stop bit. Every bit is
// BAUD_DIV clocks long.
//
// Optional feature macro: UART_ARB_PARITY_EN. When it is defined, an even
// parity slot is inserted between the data bits and the stop bit.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous, active-high reset
//   req_i         per-requester send request (level)
//   data_i        byte k is data_i[8k+7:8k]; must stay stable while req_i[k] is high
//   ack_o         one-cycle pulse when byte k is captured
//   tx_o          serial output, idles high
//   busy_o        high while a frame is in progress
//   grant_o       index of the requester that owns the current or most recent frame
//   frame_done_o  one-cycle pulse in the last clock of the stop bit
module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int BAUD_DIV = 217,
  localparam int GW      = $clog2(N_REQ),
  localparam int TW      = $clog2(BAUD_DIV)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] data_i,
  output logic [N_REQ-1:0]   ack_o,
  output logic               tx_o,
  output logic               busy_o,
  output logic [GW-1:0]      grant_o,
  output logic               frame_done_o
);

`ifdef UART_ARB_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q;
  logic [2:0]       bit_q;
  logic [7:0]       byte_q;
  logic [GW-1:0]    last_q, grant_q;
  logic [N_REQ-1:0] ack_q;
  logic [GW-1:0]    win;
  logic             win_vld;
  logic             bit_end;

  assign bit_end = (timer_q == TW'(BAUD_DIV - 1));

  // The search starts one past the previous winner, so the most recent
  // owner is tried last. This ordering is what prevents starvation.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_vld && req_i[idx]) begin
        win_vld = 1'b1;
        win     = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tx_o    = 1'b1;
    case (state_q)
      S_IDLE:  if (win_vld) state_d = S_START;
      S_START: begin
        tx_o = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx_o = byte_q[bit_q];
        if (bit_end && bit_q == 3'd7) begin
`ifdef UART_ARB_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_ARB_PARITY_EN
      S_PARITY: begin
        tx_o = ^byte_q;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP:  if (bit_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      last_q  <= GW'(N_REQ - 1);
      grant_q <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      if (state_q == S_IDLE) begin
        // The timer is held at 0 in IDLE, so the start bit always gets a
        // full BAUD_DIV clocks.
        timer_q <= '0;
        bit_q   <= '0;
        if (win_vld) begin
          byte_q      <= data_i[8*int'(win) +: 8];
          grant_q     <= win;
          last_q      <= win;
          ack_q[win]  <= 1'b1;
        end
      end else begin
        timer_q <= bit_end ? '0 : timer_q + TW'(1);
        if (state_q == S_DATA && bit_end) bit_q <= bit_q + 3'd1;
      end
    end
  end

  assign ack_o        = ack_q;
  assign busy_o       = (state_q != S_IDLE);
  assign grant_o      = grant_q;
  assign frame_done_o = (state_q == S_STOP) && bit_end;

endmodule
